// File: rtl/ram4_sequencer_if.sv
// ram4_sequencer_if
//   Bundles the command handshake, the response and the RAM/accumulator
//   datapath bus that the sequencer sits between.
//   master : command source and datapath read side. It drives cmd_valid,
//            cmd_op, cmd_addr, cmd_data and ram_q, and observes the rest.
//   slave  : the sequencer. It drives cmd_ready, ram_addr, ram_d, ram_we,
//            acc_ld, rsp_valid, rd_data and cmd_count.
`timescale 1ns/1ps
interface ram4_sequencer_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_d;
    logic              ram_we;
    logic              acc_ld;
    logic [DATA_W-1:0] ram_q;
    logic              rsp_valid;
    logic [DATA_W-1:0] rd_data;
    logic [3:0]        cmd_count;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, ram_q,
        input  cmd_ready, ram_addr, ram_d, ram_we, acc_ld,
               rsp_valid, rd_data, cmd_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, ram_q,
        output cmd_ready, ram_addr, ram_d, ram_we, acc_ld,
               rsp_valid, rd_data, cmd_count
    );
endinterface

// File: rtl/ram4_sequencer.sv
// ram4_sequencer
//   Command-driven controller for the 4-word x 4-bit register RAM and
//   accumulator datapath. It accepts WRITE / READ / LOAD_ACC / FILL commands
//   over a valid/ready handshake and drives address, write data and the two
//   strobes. Address and data are stable SETUP_CYC cycles before a strobe and
//   HOLD_CYC cycles after it. It captures read data and signals completion
//   with a one-cycle response pulse.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - ram4_sequencer_if.slave:
//            cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data  command handshake
//            ram_addr/ram_d/ram_we/acc_ld/ram_q            datapath bus
//            rsp_valid/rd_data/cmd_count                   completion status
`timescale 1ns/1ps
module ram4_sequencer #(
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 4,
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    ram4_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETUP  = 2'b01,
        S_STROBE = 2'b10,
        S_HOLD   = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE    = 2'b00,
        OP_READ     = 2'b01,
        OP_LOAD_ACC = 2'b10,
        OP_FILL     = 2'b11
    } op_t;

    // The timer only ever holds SETUP_CYC-1 or HOLD_CYC-1 and counts down.
    localparam int T_MAX   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int TIMER_W = (T_MAX < 2) ? 1 : $clog2(T_MAX);
    localparam logic [TIMER_W-1:0] T_SETUP   = TIMER_W'(SETUP_CYC - 1);
    localparam logic [TIMER_W-1:0] T_HOLD    = TIMER_W'(HOLD_CYC - 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    op_t               r_op;
    logic [TIMER_W-1:0] r_timer;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_d;
    logic              r_we;
    logic              r_ld;
    logic              r_rsp;
    logic [DATA_W-1:0] r_rd;
    logic [3:0]        r_cnt;

    logic              w_ready;
    logic              w_accept;
    logic              w_timer_done;
    logic              w_fill_more;
    logic              w_we_nxt;
    logic              w_ld_nxt;
    logic              w_rsp_nxt;

    assign w_ready      = (r_state == S_IDLE);
    assign w_accept     = w_ready & bus.cmd_valid;
    assign w_timer_done = (r_timer == '0);
    // FILL walks every word; it ends after the top address has been written.
    assign w_fill_more  = (r_op == OP_FILL) && (r_addr != ADDR_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)     w_state_nxt = S_SETUP;
            S_SETUP:  if (w_timer_done) w_state_nxt = S_STROBE;
            S_STROBE:                   w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (w_timer_done) begin
                    w_state_nxt = w_fill_more ? S_SETUP : S_IDLE;
                end
            end
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode. Strobes are computed one cycle early from the next
    // state and then registered, so the datapath sees clean flop outputs
    // that it can safely use as clocks.
    always_comb begin
        w_we_nxt  = 1'b0;
        w_ld_nxt  = 1'b0;
        w_rsp_nxt = 1'b0;
        if (w_state_nxt == S_STROBE) begin
            w_we_nxt = (r_op == OP_WRITE) || (r_op == OP_FILL);
            w_ld_nxt = (r_op == OP_LOAD_ACC);
        end
        if ((r_state == S_HOLD) && (w_state_nxt == S_IDLE)) begin
            w_rsp_nxt = 1'b1;
        end
    end

    // Registered outputs, command latch and timer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= OP_WRITE;
            r_timer <= '0;
            r_addr  <= '0;
            r_d     <= '0;
            r_we    <= 1'b0;
            r_ld    <= 1'b0;
            r_rsp   <= 1'b0;
            r_rd    <= '0;
            r_cnt   <= '0;
        end else begin
            r_we  <= w_we_nxt;
            r_ld  <= w_ld_nxt;
            r_rsp <= w_rsp_nxt;
            if (w_rsp_nxt) begin
                r_cnt <= r_cnt + 4'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= op_t'(bus.cmd_op);
                        r_addr  <= (op_t'(bus.cmd_op) == OP_FILL) ? '0 : bus.cmd_addr;
                        r_d     <= bus.cmd_data;
                        r_timer <= T_SETUP;
                    end
                end
                S_SETUP: begin
                    if (!w_timer_done) begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_STROBE: begin
                    // Address is still stable here, so the read mux output is valid.
                    if (r_op == OP_READ) begin
                        r_rd <= bus.ram_q;
                    end
                    r_timer <= T_HOLD;
                end
                S_HOLD: begin
                    if (!w_timer_done) begin
                        r_timer <= r_timer - 1'b1;
                    end else if (w_fill_more) begin
                        r_addr  <= r_addr + 1'b1;
                        r_timer <= T_SETUP;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = w_ready;
    assign bus.ram_addr  = r_addr;
    assign bus.ram_d     = r_d;
    assign bus.ram_we    = r_we;
    assign bus.acc_ld    = r_ld;
    assign bus.rsp_valid = r_rsp;
    assign bus.rd_data   = r_rd;
    assign bus.cmd_count = r_cnt;

endmodule
